// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: for each layer it fetches a 4-word
// descriptor, then runs the loader through input, weight and output
// phases, one command at a time.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                run request (sampled only when idle)
//   num_layers           number of layers in the run (latched on start)
//   desc_base            word address of the descriptor table (latched)
//   desc_rvalid          descriptor read request, held until desc_rready
//   desc_raddr           descriptor word address
//   desc_rready          read strobe; desc_rdata is valid with it
//   desc_rdata           descriptor word
//   cin, cout            layer dimensions for the loader
//   has_bias, act_type   layer configuration for the loader
//   lif_start            input-feature load command pulse
//   lw_start             weight load command pulse
//   sof_start            output store command pulse
//   base_addr            address for the command in flight
//   ld_done              loader completion pulse
//   busy                 run in progress
//   done                 one-cycle end-of-run pulse
//   err                  sticky: at least one layer was skipped
//   layer_idx            index of the layer in progress
module fc_layer_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  num_layers,
    input  logic [25:0] desc_base,
    output logic        desc_rvalid,
    output logic [25:0] desc_raddr,
    input  logic        desc_rready,
    input  logic [31:0] desc_rdata,
    output logic [10:0] cin,
    output logic [10:0] cout,
    output logic        has_bias,
    output logic [4:0]  act_type,
    output logic        lif_start,
    output logic        lw_start,
    output logic        sof_start,
    output logic [26:0] base_addr,
    input  logic        ld_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  layer_idx
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LIF,
        S_WLIF,
        S_LW,
        S_WLW,
        S_SOF,
        S_WSOF,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  nl_q;
    logic [25:0] tbl_q;
    logic [3:0]  idx_q;
    logic [1:0]  word_q;
    logic        rvalid_q;
    logic [25:0] raddr_q;
    logic [10:0] cin_q;
    logic [10:0] cout_q;
    logic        bias_q;
    logic [4:0]  act_q;
    logic [26:0] k1_q;
    logic [26:0] k2_q;
    logic [26:0] k3_q;
    logic [26:0] base_q;
    logic        lif_q;
    logic        lw_q;
    logic        sof_q;
    logic        done_q;
    logic        err_q;

    logic [25:0] fetch_addr_d;
    logic        ld_ack_d;
    logic        skip_d;
    logic        unused_bits;

    // First word of the current layer's descriptor (26-bit wrap).
    assign fetch_addr_d = tbl_q + 26'({idx_q, 2'b00});

    // A completion arriving together with a command pulse belongs to
    // nothing we issued, so it is not taken as the acknowledge.
    assign ld_ack_d = ld_done & ~(lif_q | lw_q | sof_q);

    assign skip_d = (cin_q == 11'd0) || (cout_q == 11'd0);

    assign unused_bits = ^desc_rdata[31:28];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            nl_q     <= '0;
            tbl_q    <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            cin_q    <= '0;
            cout_q   <= '0;
            bias_q   <= 1'b0;
            act_q    <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            k3_q     <= '0;
            base_q   <= '0;
            lif_q    <= 1'b0;
            lw_q     <= 1'b0;
            sof_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lif_q  <= 1'b0;
            lw_q   <= 1'b0;
            sof_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nl_q    <= num_layers;
                        tbl_q   <= desc_base;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        word_q  <= '0;
                        state_q <= (num_layers != 4'd0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (!rvalid_q) begin
                        // Entry cycle: raise the request for word 0.
                        rvalid_q <= 1'b1;
                        raddr_q  <= fetch_addr_d;
                    end else if (desc_rready) begin
                        unique case (word_q)
                            2'd0: begin
                                cin_q  <= desc_rdata[10:0];
                                cout_q <= desc_rdata[21:11];
                                bias_q <= desc_rdata[22];
                                act_q  <= desc_rdata[27:23];
                            end
                            2'd1: k1_q <= desc_rdata[26:0];
                            2'd2: k2_q <= desc_rdata[26:0];
                            2'd3: k3_q <= desc_rdata[26:0];
                        endcase
                        word_q <= word_q + 2'd1;
                        if (word_q == 2'd3) begin
                            rvalid_q <= 1'b0;
                            if (skip_d) begin
                                err_q   <= 1'b1;
                                state_q <= S_NEXT;
                            end else begin
                                state_q <= S_LIF;
                            end
                        end else begin
                            raddr_q <= raddr_q + 26'd1;
                        end
                    end
                end
                S_LIF: begin
                    lif_q   <= 1'b1;
                    base_q  <= k1_q;
                    state_q <= S_WLIF;
                end
                S_WLIF: begin
                    if (ld_ack_d) state_q <= S_LW;
                end
                S_LW: begin
                    lw_q    <= 1'b1;
                    base_q  <= k2_q;
                    state_q <= S_WLW;
                end
                S_WLW: begin
                    if (ld_ack_d) state_q <= S_SOF;
                end
                S_SOF: begin
                    sof_q   <= 1'b1;
                    base_q  <= k3_q;
                    state_q <= S_WSOF;
                end
                S_WSOF: begin
                    if (ld_ack_d) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx_q == 4'(nl_q - 4'd1)) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        word_q  <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign desc_rvalid = rvalid_q;
    assign desc_raddr  = raddr_q;
    assign cin         = cin_q;
    assign cout        = cout_q;
    assign has_bias    = bias_q;
    assign act_type    = act_q;
    assign lif_start   = lif_q;
    assign lw_start    = lw_q;
    assign sof_start   = sof_q;
    assign base_addr   = base_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign layer_idx   = idx_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer: descriptor memory and loader
// responders, plus an event-level reference model of a network run.
module tb_fc_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_layers;
    logic [25:0] desc_base;
    logic        desc_rvalid;
    logic [25:0] desc_raddr;
    logic        desc_rready;
    logic [31:0] desc_rdata;
    logic [10:0] cin;
    logic [10:0] cout;
    logic        has_bias;
    logic [4:0]  act_type;
    logic        lif_start;
    logic        lw_start;
    logic        sof_start;
    logic [26:0] base_addr;
    logic        ld_done;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  layer_idx;

    fc_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .num_layers(num_layers), .desc_base(desc_base),
        .desc_rvalid(desc_rvalid), .desc_raddr(desc_raddr),
        .desc_rready(desc_rready), .desc_rdata(desc_rdata),
        .cin(cin), .cout(cout), .has_bias(has_bias),
        .act_type(act_type), .lif_start(lif_start),
        .lw_start(lw_start), .sof_start(sof_start),
        .base_addr(base_addr), .ld_done(ld_done), .busy(busy),
        .done(done), .err(err), .layer_idx(layer_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [26:0] addr;
        logic [3:0]  idx;
        logic [10:0] cin;
        logic [10:0] cout;
        logic        bias;
        logic [4:0]  act;
    } cmd_t;

    logic [31:0] mem [logic [25:0]];
    logic [25:0] rd_q [$];
    cmd_t        cmd_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt, done_cyc, rv_cnt, viol;
    int rdelay, ldelay;
    bit spur_ld, spur_rr, early_ld;
    int wcnt, lcnt;
    bit pend, prev_wait;
    logic [25:0] prev_addr;
    logic [26:0] hold;
    cmd_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Environment: memory + loader responder and protocol monitor.
    always @(negedge clk) begin
        desc_rready = 1'b0;
        ld_done = 1'b0;
        if (rst) begin
            wcnt = 0;
            pend = 0;
            prev_wait = 0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (desc_rvalid) rv_cnt++;
            if (int'(lif_start) + int'(lw_start) + int'(sof_start) > 1)
                viol++;
            if (pend && (lif_start || lw_start || sof_start)) viol++;
            if (pend && base_addr !== hold) viol++;
            if (desc_rvalid && prev_wait && desc_raddr !== prev_addr)
                viol++;
            prev_wait = 0;
            if (desc_rvalid) begin
                if (wcnt >= rdelay) begin
                    desc_rready = 1'b1;
                    desc_rdata = mem[desc_raddr];
                    rd_q.push_back(desc_raddr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                    prev_wait = 1;
                    prev_addr = desc_raddr;
                end
            end else begin
                wcnt = 0;
                if (spur_rr) begin
                    desc_rready = 1'b1;
                    desc_rdata = $urandom;
                end
            end
            if (lif_start || lw_start || sof_start) begin
                cur.kind = lif_start ? 2'd1 : (lw_start ? 2'd2 : 2'd3);
                cur.addr = base_addr;
                cur.idx = layer_idx;
                cur.cin = cin;
                cur.cout = cout;
                cur.bias = has_bias;
                cur.act = act_type;
                cmd_q.push_back(cur);
                pend = 1;
                lcnt = ldelay;
                hold = base_addr;
                if (early_ld) ld_done = 1'b1;
            end else if (pend) begin
                if (lcnt == 0) begin
                    ld_done = 1'b1;
                    pend = 0;
                end else begin
                    lcnt--;
                end
            end else if (spur_ld && desc_rvalid) begin
                ld_done = 1'b1;
            end
        end
    end

    task automatic fill(input logic [25:0] base, input int nl,
                        input int zl);
        for (int i = 0; i < nl; i++) begin
            logic [25:0] a;
            logic [31:0] w;
            a = base + 26'(4 * i);
            w = $urandom;
            w[10:0] = 11'($urandom_range(1, 2047));
            w[21:11] = 11'($urandom_range(1, 2047));
            if (i == zl) begin
                if ($urandom_range(0, 1) == 1) w[10:0] = '0;
                else w[21:11] = '0;
            end
            mem[a] = w;
            for (int k = 1; k < 4; k++) mem[a + 26'(k)] = $urandom;
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        cmd_q.delete();
        done_cnt = 0;
        rv_cnt = 0;
        viol = 0;
    endtask

    // One network run compared against the event-level model.
    task automatic run_net(input logic [3:0] nl, input logic [25:0] base,
                           input bit restart);
        logic [25:0] exp_r [$];
        cmd_t exp_c [$];
        bit exp_err;
        int t0, t;
        exp_err = 0;
        for (int i = 0; i < int'(nl); i++) begin
            logic [25:0] a;
            logic [31:0] w0, wk;
            a = base + 26'(4 * i);
            for (int k = 0; k < 4; k++) exp_r.push_back(a + 26'(k));
            w0 = mem[a];
            if (w0[10:0] == 0 || w0[21:11] == 0) begin
                exp_err = 1;
            end else begin
                for (int k = 1; k < 4; k++) begin
                    cmd_t c;
                    wk = mem[a + 26'(k)];
                    c.kind = 2'(k);
                    c.addr = wk[26:0];
                    c.idx = 4'(i);
                    c.cin = w0[10:0];
                    c.cout = w0[21:11];
                    c.bias = w0[22];
                    c.act = w0[27:23];
                    exp_c.push_back(c);
                end
            end
        end
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        num_layers = nl;
        desc_base = base;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        num_layers = 4'($urandom);
        desc_base = 26'($urandom);
        if (restart) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            num_layers = 4'd5;
            desc_base = base + 26'h100;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("rd_count", 64'(rd_q.size()), 64'(exp_r.size()));
        for (int i = 0; i < rd_q.size() && i < exp_r.size(); i++)
            chk("rd_addr", 64'(rd_q[i]), 64'(exp_r[i]));
        chk("cmd_count", 64'(cmd_q.size()), 64'(exp_c.size()));
        for (int i = 0; i < cmd_q.size() && i < exp_c.size(); i++)
            chk("cmd", 64'(cmd_q[i]), 64'(exp_c[i]));
        chk("err", 64'(err), 64'(exp_err));
        chk("protocol", 64'(viol), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("idx_end", 64'(layer_idx), (nl == 0) ? 64'd0 : 64'(nl - 1));
        if (nl == 0) begin
            chk("done_lat", 64'(done_cyc - t0), 64'd2);
            chk("rvalid_none", 64'(rv_cnt), 64'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, 64'({desc_rvalid, desc_raddr, cin, cout,
                              has_bias, act_type}), 64'd0);
        chk({tag, "_b"}, 64'({lif_start, lw_start, sof_start, base_addr,
                              busy, done, err, layer_idx}), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0] nl;
        logic [25:0] b;
        int zl, t;
        rst = 1'b1;
        start = 1'b0;
        num_layers = '0;
        desc_base = '0;
        desc_rready = 1'b0;
        desc_rdata = '0;
        ld_done = 1'b0;
        rdelay = 0;
        ldelay = 1;
        spur_ld = 0;
        spur_rr = 0;
        early_ld = 0;
        clear_logs();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Single directed layer.
        mem[26'h0] = (32'd3 << 23) | (32'd1 << 22) | (32'd2 << 11) | 32'd4;
        mem[26'h1] = 32'h100;
        mem[26'h2] = 32'h200;
        mem[26'h3] = 32'h300;
        run_net(4'd1, 26'h0, 0);

        // Three layers from 0x40, with a start pulse while busy.
        rdelay = 1;
        ldelay = 2;
        fill(26'h40, 3, -1);
        run_net(4'd3, 26'h40, 1);

        // Empty network.
        run_net(4'd0, 26'h1234, 0);

        // First of two layers has cout == 0.
        fill(26'h800, 2, -1);
        w = mem[26'h800];
        w[21:11] = '0;
        mem[26'h800] = w;
        run_net(4'd2, 26'h800, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);

        // Slow descriptor memory, noisy strobes, table wrapping at 2^26.
        rdelay = 5;
        spur_ld = 1;
        spur_rr = 1;
        early_ld = 1;
        fill(26'h3FFFFFA, 2, -1);
        run_net(4'd2, 26'h3FFFFFA, 0);
        spur_ld = 0;
        spur_rr = 0;
        early_ld = 0;

        // Randomised runs, one of them at the maximum layer count.
        for (int r = 0; r < 6; r++) begin
            nl = (r == 0) ? 4'd15 : 4'($urandom_range(1, 15));
            b = 26'($urandom);
            zl = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, int'(nl) - 1)) : -1;
            rdelay = $urandom_range(0, 3);
            ldelay = $urandom_range(0, 4);
            spur_ld = 1'($urandom_range(0, 1));
            spur_rr = 1'($urandom_range(0, 1));
            early_ld = 1'($urandom_range(0, 1));
            fill(b, int'(nl), zl);
            run_net(nl, b, 1'($urandom_range(0, 1)));
        end
        spur_ld = 0;
        spur_rr = 0;
        early_ld = 0;

        // Reset while waiting on the weight load.
        rdelay = 0;
        ldelay = 20;
        fill(26'h2000, 1, -1);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        num_layers = 4'd1;
        desc_base = 26'h2000;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (cmd_q.size() < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("pre_rst_cmds", 64'(cmd_q.size()), 64'd2);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrun_rst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_resume", 64'(busy), 64'd0);
        ldelay = 1;
        run_net(4'd1, 26'h2000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
